// File: rtl/cjb_io_input_cond.sv
// Input conditioning for the push-button and slide switches: two-flop synchronisers,
// per-line debounce, edge pulses and a sticky press flag acknowledged by the IPDR load.
`timescale 1ns/1ps
module cjb_io_input_cond #(
  parameter int NSW       = 4,
  parameter int DB_CYCLES = 250000,
  parameter int CNT_W     = 18
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           PB_raw,
  input  logic [NSW-1:0] SW_raw,
  input  logic           PB_ack,
  output logic           PB1,
  output logic           PB1_pulse,
  output logic           PB1_evt,
  output logic [NSW-1:0] SW,
  output logic [NSW-1:0] SW_chg
);

  // Line 0 is the button (active-high after inversion), lines 1..NSW are the switches.
  localparam int NL = NSW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {
    EVT_EMPTY   = 1'b0,
    EVT_PENDING = 1'b1
  } evt_state_t;

  logic           pb_s1_reg;
  logic           pb_s2_reg;
  logic [NSW-1:0] sw_s1_reg;
  logic [NSW-1:0] sw_s2_reg;
  logic [NL-1:0]  line_sync;
  logic [NL-1:0]  st_vec;
  logic [NL-1:0]  chg_vec;
  evt_state_t     evt_state_reg;

  // Button sync flops rest at 1 so a reset never looks like a press.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pb_s1_reg <= 1'b1;
      pb_s2_reg <= 1'b1;
      sw_s1_reg <= '0;
      sw_s2_reg <= '0;
    end else begin
      pb_s1_reg <= PB_raw;
      pb_s2_reg <= pb_s1_reg;
      sw_s1_reg <= SW_raw;
      sw_s2_reg <= sw_s1_reg;
    end
  end

  assign line_sync = {sw_s2_reg, ~pb_s2_reg};

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_line
      logic [CNT_W-1:0] cnt_reg;
      logic             st_reg;
      logic             st_d_reg;
      logic             chg_reg;

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          cnt_reg  <= '0;
          st_reg   <= 1'b0;
          st_d_reg <= 1'b0;
          chg_reg  <= 1'b0;
        end else begin
          st_d_reg <= st_reg;
          // The button only reports presses; switches report both directions.
          chg_reg  <= (gi == 0) ? (st_reg & ~st_d_reg) : (st_reg ^ st_d_reg);
          if (line_sync[gi] == st_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            st_reg  <= line_sync[gi];
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign st_vec[gi]  = st_reg;
      assign chg_vec[gi] = chg_reg;
    end
  endgenerate

  // A press arriving together with the acknowledge must survive.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      evt_state_reg <= EVT_EMPTY;
    end else begin
      case (evt_state_reg)
        EVT_EMPTY:   if (chg_vec[0]) evt_state_reg <= EVT_PENDING;
        EVT_PENDING: if (PB_ack && !chg_vec[0]) evt_state_reg <= EVT_EMPTY;
        default:     evt_state_reg <= EVT_EMPTY;
      endcase
    end
  end

  assign PB1       = st_vec[0];
  assign PB1_pulse = chg_vec[0];
  assign PB1_evt   = (evt_state_reg == EVT_PENDING);
  assign SW        = st_vec[NL-1:1];
  assign SW_chg    = chg_vec[NL-1:1];

endmodule
